toggle_bank_arbiter: RTL
========================

Name: toggle_bank_arbiter

Overview:
Shares one bank of WIDTH T-flip-flops among NUM_REQ requesters.
Each requester presents a toggle mask. A round-robin arbiter selects one requester and drives the bank's T inputs with that mask for exactly one cycle. The winner then gets a one-cycle grant pulse.
Sits between control agents (counters, dividers, pattern generators) and the shared toggle state register q.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, width of the toggle bank / mask

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester request, level; held until gnt
mask  input  NUM_REQ*WIDTH  per-requester toggle mask; requester i uses bits [i*WIDTH +: WIDTH]; stable while req[i]=1
gnt  output  NUM_REQ  one-hot, one-cycle grant pulse
t_vec  output  WIDTH  T inputs applied to the bank this cycle
q  output  WIDTH  toggle bank state
busy  output  1  high in APPLY state
grant_cnt  output  NUM_REQ*8  per-requester grant counters; exists only when TBANK_STATS_EN is defined

Behaviour:
- Reset (async assert, sync deassert by design):
  - q=0, gnt=0, t_vec=0, busy=0
  - state=IDLE, round-robin pointer=0
- State machine: IDLE, APPLY.
  - IDLE:
    - If any req bit is set, pick the winner: first set bit at or after the pointer, wrapping modulo NUM_REQ.
    - Register the winner index and its mask, then go to APPLY.
    - If no req bit is set, stay in IDLE; outputs stay 0.
  - APPLY (exactly 1 cycle):
    - gnt[winner]=1, t_vec=registered mask, busy=1.
    - At the closing edge: q <= q ^ mask, pointer <= winner+1 (wraps to 0 after NUM_REQ-1), state <= IDLE.
- Latency:
  - req sampled high in cycle N gives gnt and t_vec in cycle N+1.
  - The new q is visible in cycle N+2.
- Throughput: at most one grant per 2 cycles.
- Handshake:
  - A requester deasserts req the cycle after it sees gnt.
  - req still high in the next IDLE counts as a new request. Because the pointer has advanced, other requesters get priority.
- Masks are registered in IDLE, so mask changes during APPLY have no effect.
- All-zero mask: the requester is still granted; q is unchanged; t_vec=0.
- Simultaneous requests: only one grant per APPLY. Losing requesters keep req high and are served in rotation. There is no starvation: worst-case wait is 2*NUM_REQ cycles.
- Reset asserted during APPLY: gnt drops immediately and the q update is discarded (q=0).
- q is never written outside APPLY.

Optional Feature:
TBANK_STATS_EN
- Defined:
  - grant_cnt port and logic are present.
  - Each requester has an 8-bit saturating counter that increments in its APPLY cycle and holds at 255.
  - Cleared by rst.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package tbank_pkg contains:
  - state enum {IDLE, APPLY}
  - function clog2-based index width for NUM_REQ
  - STAT_W=8 and STAT_MAX=255 constants
- One sub-module: tbank_rr_arb.
  - Combinational round-robin priority pick from req and pointer.
  - Outputs: winner index and a valid flag.
  - The top module owns the FSM, mask register, q bank, pointer register and counters.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then 0, with req=0 for 5 cycles. Expect q=0, gnt=0, t_vec=0, busy=0 throughout.
2. Single request: req=0001, mask0=8'hA5 in cycle N.
   - Cycle N+1: gnt=0001, t_vec=A5.
   - Cycle N+2: q=A5.
   - Repeat the request: q returns to 00.
3. Contention and rotation: req=1111 held, masks 01/02/04/08.
   - Grant order 0,1,2,3,0, one grant every 2 cycles.
   - After four grants q=0F. After the fifth grant q=0E.
4. Zero mask and wrap: pointer=3, req=1001, mask3=00. Expect gnt=1000, q unchanged, next grant to requester 0.
5. Reset during APPLY: assert rst in the APPLY cycle. Expect gnt=0 immediately, q=0, pointer=0, next grant from requester 0.
6. TBANK_STATS_EN defined: grant requester 2 exactly 300 times. Expect grant_cnt[2]=255 and all other counters 0.

Source files
------------

// File: rtl/tbank_pkg.sv
// Shared types and constants for the toggle bank arbiter.
// The TBANK_STATS_EN build option uses STAT_W/STAT_MAX for the per-requester grant counters.
package tbank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } tbank_state_t;

  localparam int unsigned STAT_W   = 8;
  localparam int unsigned STAT_MAX = 255;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tbank_rr_arb.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping modulo NUM_REQ.
module tbank_rr_arb
  import tbank_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  always_comb begin : pick
    logic [IW-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IW'((32'(ptr) + k) % NUM_REQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/toggle_bank_arbiter.sv
// Round-robin sharing of one WIDTH-bit T-flip-flop bank among NUM_REQ requesters.
// Define TBANK_STATS_EN to add the grant_cnt port and saturating per-requester grant counters.
module toggle_bank_arbiter
  import tbank_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   mask,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]           t_vec,
  output logic [WIDTH-1:0]           q,
  output logic                       busy
`ifdef TBANK_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]  grant_cnt
`endif
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  tbank_state_t   state, state_nxt;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  win_idx;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] q_reg;
  logic [IW-1:0]  arb_win;
  logic           arb_valid;
  logic [WIDTH-1:0] sel_mask;

  tbank_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (arb_win),
    .valid  (arb_valid)
  );

  always_comb begin
    sel_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == arb_win) sel_mask = mask[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_valid) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from registered state so an async reset clears them at once.
  always_comb begin
    gnt   = '0;
    t_vec = '0;
    busy  = 1'b0;
    if (state == APPLY) begin
      gnt[win_idx] = 1'b1;
      t_vec        = mask_reg;
      busy         = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      win_idx  <= '0;
      mask_reg <= '0;
      q_reg    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            win_idx  <= arb_win;
            mask_reg <= sel_mask;
          end
        end
        APPLY: begin
          q_reg <= q_reg ^ mask_reg;
          ptr   <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign q = q_reg;

`ifdef TBANK_STATS_EN
  logic [STAT_W-1:0] cnt [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (state == APPLY && cnt[win_idx] != STAT_W'(STAT_MAX)) begin
      cnt[win_idx] <= cnt[win_idx] + STAT_W'(1);
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i*STAT_W +: STAT_W] = cnt[i];
  end
`endif

endmodule
